// File: rtl/model_standard_transformer_sequencer.sv
// model_standard_transformer_sequencer: streams W, B and X from parameter memory into the controller, runs it and captures H.
module model_standard_transformer_sequencer #(
   parameter int DATA_SIZE    = 64,
   parameter int CONTROL_SIZE = 64
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 START,
   output logic                 READY,
   output logic                 ERROR,
   input  logic [DATA_SIZE-1:0] SIZE_X_IN,
   input  logic [DATA_SIZE-1:0] SIZE_L_IN,
   output logic [DATA_SIZE-1:0] MEM_ADDR,
   input  logic [DATA_SIZE-1:0] MEM_RDATA,
   output logic                 H_WE,
   output logic [DATA_SIZE-1:0] H_ADDR,
   output logic [DATA_SIZE-1:0] H_DATA,
   output logic                 CTRL_START,
   input  logic                 CTRL_READY,
   output logic                 CTRL_W_IN_L_ENABLE,
   output logic                 CTRL_W_IN_X_ENABLE,
   output logic                 CTRL_B_IN_ENABLE,
   output logic                 CTRL_X_IN_ENABLE,
   input  logic                 CTRL_W_OUT_L_ENABLE,
   input  logic                 CTRL_W_OUT_X_ENABLE,
   input  logic                 CTRL_B_OUT_ENABLE,
   input  logic                 CTRL_X_OUT_ENABLE,
   output logic [DATA_SIZE-1:0] CTRL_W_IN,
   output logic [DATA_SIZE-1:0] CTRL_B_IN,
   output logic [DATA_SIZE-1:0] CTRL_X_IN,
   input  logic                 CTRL_H_OUT_ENABLE,
   input  logic [DATA_SIZE-1:0] CTRL_H_OUT
);
   if (CONTROL_SIZE < 1) begin : g_bad_control_size
      $error("CONTROL_SIZE must be positive");
   end
   typedef enum logic [2:0] {IDLE, FETCH, PRESENT, WAIT_ACK, WAIT_ROW, RUN, DONE} state_t;
   typedef enum logic [1:0] {PH_W, PH_B, PH_X} phase_t;
   localparam logic [DATA_SIZE-1:0] ONE = 1;
   state_t state;
   phase_t phase;
   logic [DATA_SIZE-1:0] size_x, size_l, i, j, h_cnt, h_next;
   logic ovf, ack, last_col, last_row, h_take;
   // an ack in the strobe cycle itself belongs to the previous element and is dropped
   always_comb begin
      ack = (phase == PH_W ? CTRL_W_OUT_X_ENABLE : phase == PH_B ? CTRL_B_OUT_ENABLE : CTRL_X_OUT_ENABLE)
            && !(CTRL_W_IN_X_ENABLE || CTRL_B_IN_ENABLE || CTRL_X_IN_ENABLE);
      last_col = j == (phase == PH_B ? size_l : size_x) - ONE;
      last_row = i == size_l - ONE;
      h_take = CTRL_H_OUT_ENABLE && h_cnt < size_l;
      h_next = h_cnt + {{(DATA_SIZE-1){1'b0}}, CTRL_H_OUT_ENABLE};
   end
   // MEM_ADDR is itself the running address counter
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         phase <= PH_W;
         {size_x, size_l, i, j, h_cnt, MEM_ADDR, H_ADDR, H_DATA} <= '0;
         {CTRL_W_IN, CTRL_B_IN, CTRL_X_IN} <= '0;
         {ovf, READY, ERROR, H_WE, CTRL_START} <= '0;
         {CTRL_W_IN_L_ENABLE, CTRL_W_IN_X_ENABLE, CTRL_B_IN_ENABLE, CTRL_X_IN_ENABLE} <= '0;
      end else begin
         {READY, H_WE, CTRL_START} <= '0;
         {CTRL_W_IN_L_ENABLE, CTRL_W_IN_X_ENABLE, CTRL_B_IN_ENABLE, CTRL_X_IN_ENABLE} <= '0;
         case (state)
            IDLE: if (START) begin
               size_x <= SIZE_X_IN;
               size_l <= SIZE_L_IN;
               {phase, i, j, h_cnt, MEM_ADDR, ovf} <= '0;
               ERROR <= SIZE_X_IN == '0 || SIZE_L_IN == '0;
               READY <= SIZE_X_IN == '0 || SIZE_L_IN == '0;
               state <= SIZE_X_IN == '0 || SIZE_L_IN == '0 ? DONE : FETCH;
            end
            FETCH: state <= PRESENT;
            PRESENT: begin
               state <= WAIT_ACK;
               case (phase)
                  PH_W: begin
                     CTRL_W_IN <= MEM_RDATA;
                     CTRL_W_IN_X_ENABLE <= 1'b1;
                     CTRL_W_IN_L_ENABLE <= j == '0;
                  end
                  PH_B: begin
                     CTRL_B_IN <= MEM_RDATA;
                     CTRL_B_IN_ENABLE <= 1'b1;
                  end
                  default: begin
                     CTRL_X_IN <= MEM_RDATA;
                     CTRL_X_IN_ENABLE <= 1'b1;
                  end
               endcase
            end
            WAIT_ACK: if (ack) begin
               MEM_ADDR <= MEM_ADDR + ONE;
               j <= last_col ? '0 : j + ONE;
               state <= FETCH;
               if (last_col && phase == PH_W) begin
                  if (!CTRL_W_OUT_L_ENABLE) state <= WAIT_ROW;
                  else begin
                     i <= i + ONE;
                     if (last_row) phase <= PH_B;
                  end
               end else if (last_col && phase == PH_B) phase <= PH_X;
               else if (last_col) begin
                  state <= RUN;
                  CTRL_START <= 1'b1;
               end
            end
            WAIT_ROW: if (CTRL_W_OUT_L_ENABLE) begin
               state <= FETCH;
               i <= i + ONE;
               if (last_row) phase <= PH_B;
            end
            RUN: begin
               H_WE <= h_take;
               if (h_take) begin
                  H_ADDR <= h_cnt;
                  H_DATA <= CTRL_H_OUT;
               end
               if (CTRL_H_OUT_ENABLE) h_cnt <= h_next;
               if (CTRL_H_OUT_ENABLE && !h_take) ovf <= 1'b1;
               if (CTRL_READY) begin
                  state <= DONE;
                  READY <= 1'b1;
                  ERROR <= h_next != size_l || ovf || (CTRL_H_OUT_ENABLE && !h_take);
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
